// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-port round-robin sequencer in front of a single-port
// memory. It accepts one command at a time and drives one memory access per
// grant. For a read, it waits for valid_out and returns the data to the
// granted port. All outputs are registered.
// Optional build macro MEM_ARB_TIMEOUT_EN: aborts a read that gets no
// valid_out within TIMEOUT_CYCLES cycles, and reports the abort on rerr.
module mem_access_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic                  rerr,
   output logic                  busy,
   output logic                  WE,
   output logic                  RE,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] Data_in,
   input  logic [DATA_WIDTH-1:0] Data_out,
   input  logic                  valid_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   state_t                state_q, state_d;
   logic                  last_gnt_q, last_gnt_d;
   logic                  port_q, port_d;
   logic                  wr_q, wr_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  we_q, we_d, re_q, re_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                  busy_q, busy_d;
   logic                  sel, sel_we;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rerr_q, rerr_d;
`endif

   // Next-state and next-output logic; every output is computed one cycle ahead
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      port_d     = port_q;
      wr_d       = wr_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      we_d       = 1'b0;
      re_d       = 1'b0;
      addr_d     = '0;
      din_d      = '0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      sel        = 1'b0;
      sel_we     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      rerr_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               // On a tie, the port that was not granted last wins
               sel        = (req0 & req1) ? ~last_gnt_q : req1;
               sel_we     = sel ? we1 : we0;
               state_d    = ISSUE;
               last_gnt_d = sel;
               port_d     = sel;
               wr_d       = sel_we;
               gnt0_d     = ~sel;
               gnt1_d     = sel;
               we_d       = sel_we;
               re_d       = ~sel_we;
               addr_d     = sel ? addr1 : addr0;
               din_d      = sel_we ? (sel ? wdata1 : wdata0) : '0;
            end
         end
         ISSUE: begin
            state_d = wr_q ? IDLE : WAIT_RD;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_RD: begin
            if (valid_out) begin
               state_d = IDLE;
               if (port_q) begin
                  rdata1_d  = Data_out;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = Data_out;
                  rvalid0_d = 1'b1;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Abort: return zero data flagged with rerr
               state_d = IDLE;
               rerr_d  = 1'b1;
               if (port_q) begin
                  rdata1_d  = '0;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = '0;
                  rvalid0_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; async reset clears everything mid-operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         port_q     <= 1'b0;
         wr_q       <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         rerr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         port_q     <= port_d;
         wr_q       <= wr_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         we_q       <= we_d;
         re_q       <= re_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         busy_q     <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rerr_q     <= rerr_d;
`endif
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign WE      = we_q;
   assign RE      = re_q;
   assign Address = addr_q;
   assign Data_in = din_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign busy    = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign rerr    = rerr_q;
`else
   assign rerr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a one-cycle-latency memory model.
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [3:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr, busy, WE, RE;
   logic [31:0] rdata0, rdata1, Data_in, Data_out;
   logic [3:0]  Address;
   logic        valid_out;
   logic        mute, inject;
   logic [31:0] mem [16];

   int n_cmp = 0;
   int n_mis = 0;

   mem_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rerr(rerr), .busy(busy),
      .WE(WE), .RE(RE), .Address(Address), .Data_in(Data_in),
      .Data_out(Data_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   // Memory model: read data and valid_out one cycle after RE is sampled
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
      end else begin
         if (WE) mem[Address] <= Data_in;
         if (RE) Data_out <= mem[Address];
         valid_out <= (RE & ~mute) | inject;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mute = 1'b0; inject = 1'b0; Data_out = '0;
      repeat (2) tick();
      check("rst_ctl", 64'({gnt0, gnt1, WE, RE, rvalid0, rvalid1, rerr, busy}), 64'd0);
      check("rst_addr", 64'(Address), 64'd0);
      check("rst_din", 64'(Data_in), 64'd0);
      rst = 1'b0;
      tick();

      // port 0 write addr 3
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'hDEADBEEF;
      tick();
      check("wr_gnt", 64'({gnt0, gnt1}), 64'b10);
      check("wr_strobe", 64'({WE, RE}), 64'b10);
      check("wr_addr", 64'(Address), 64'd3);
      check("wr_din", 64'(Data_in), 64'hDEADBEEF);
      check("wr_busy", 64'(busy), 64'd1);
      req0 = 1'b0;
      tick();
      check("wr_drop", 64'({gnt0, WE, busy}), 64'd0);

      // port 0 read addr 3
      req0 = 1'b1; we0 = 1'b0;
      tick();
      check("rd_gnt", 64'({gnt0, gnt1}), 64'b10);
      check("rd_strobe", 64'({WE, RE}), 64'b01);
      check("rd_addr", 64'(Address), 64'd3);
      check("rd_din", 64'(Data_in), 64'd0);
      req0 = 1'b0;
      tick();
      check("rd_wait", 64'({RE, rvalid0, busy}), 64'b001);
      tick();
      check("rd_rvalid", 64'({rvalid0, rvalid1}), 64'b10);
      check("rd_data0", 64'(rdata0), 64'hDEADBEEF);
      tick();
      check("rd_pulse", 64'({rvalid0, busy}), 64'b00);
      check("rd_hold", 64'(rdata0), 64'hDEADBEEF);

      // port 1 write then read addr 15
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'd15; wdata1 = 32'h12345678;
      tick();
      check("p1w_gnt", 64'({gnt0, gnt1}), 64'b01);
      req1 = 1'b0;
      tick();
      req1 = 1'b1; we1 = 1'b0;
      tick();
      check("p1r_gnt", 64'({gnt0, gnt1}), 64'b01);
      check("p1r_strobe", 64'({WE, RE}), 64'b01);
      check("p1r_addr", 64'(Address), 64'd15);
      req1 = 1'b0;
      repeat (2) tick();
      check("p1r_rvalid", 64'({rvalid0, rvalid1}), 64'b01);
      check("p1r_data1", 64'(rdata1), 64'h12345678);
      check("p1r_data0", 64'(rdata0), 64'hDEADBEEF);
      tick();

      // stray valid_out while idle
      inject = 1'b1;
      tick();
      inject = 1'b0;
      tick();
      check("idle_valid", 64'({rvalid0, rvalid1, busy}), 64'd0);
      tick();
      check("idle_valid2", 64'({rvalid0, rvalid1, busy}), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
      // read with valid_out withheld: abort after 8 WAIT_RD cycles
      mute = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
      tick();
      check("to_gnt", 64'(gnt1), 64'd1);
      req1 = 1'b0;
      repeat (8) tick();
      check("to_early", 64'({rvalid1, rerr, busy}), 64'b001);
      tick();
      check("to_fire", 64'({rvalid1, rerr}), 64'b11);
      check("to_data", 64'(rdata1), 64'd0);
      tick();
      check("to_done", 64'({rvalid1, rerr, busy}), 64'd0);
      mute = 1'b0;
`endif

      // reset asserted while a read is waiting
      mute = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
      tick();
      req0 = 1'b0;
      repeat (2) tick();
      check("mr_busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mr_async", 64'({gnt0, gnt1, WE, RE, rvalid0, rvalid1, rerr, busy}), 64'd0);
      check("mr_rdata", 64'(rdata0), 64'd0);
      tick();
      rst = 1'b0; mute = 1'b0;
      tick();
      check("mr_after", 64'({rvalid0, rvalid1, rerr, busy}), 64'd0);

      // both ports request writes continuously: strict alternation from port 0
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      addr0 = 4'd4; wdata0 = {28'hA000000, 4'd4};
      addr1 = 4'd8; wdata1 = {28'hB000000, 4'd8};
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i % 2 == 0) begin
            check("arb_gnt", 64'({gnt0, gnt1}), 64'b10);
            check("arb_addr", 64'(Address), 64'(4 + i / 2));
            check("arb_din", 64'(Data_in), 64'({28'hA000000, 4'(4 + i / 2)}));
            addr0 = addr0 + 4'd1;
            wdata0 = {28'hA000000, addr0};
         end else begin
            check("arb_gnt", 64'({gnt0, gnt1}), 64'b01);
            check("arb_addr", 64'(Address), 64'(8 + i / 2));
            check("arb_din", 64'(Data_in), 64'({28'hB000000, 4'(8 + i / 2)}));
            addr1 = addr1 + 4'd1;
            wdata1 = {28'hB000000, addr1};
         end
         tick();
         check("arb_gap", 64'({gnt0, gnt1}), 64'd0);
      end
      req0 = 1'b0; req1 = 1'b0;
      check("arb_mem4", 64'(mem[4]), 64'hA0000004);
      check("arb_mem9", 64'(mem[9]), 64'hB0000009);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Two grants in the same cycle are never allowed
   always @(negedge clk) begin
      if (!rst && (gnt0 || gnt1)) check("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
   end

endmodule
